// File: rtl/buzzer_seq.sv
// buzzer_seq: plays a 16-entry step table of {rest, dur, note} as timed tones.
// Each step runs LOAD (1 cycle), PLAY ((dur+1)*BEAT_CYCLES cycles), and an
// optional silent GAP (GAP_CYCLES cycles). An end-of-step decision then
// advances to the next step, loops back to step 0, or finishes.
// All outputs are registered from the next-state logic, so each output
// already matches the state it describes in the cycle that state is active.
module buzzer_seq #(
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000
) (
  input  logic       FPGA_CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [3:0] last_step,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_note,
  input  logic [3:0] wr_dur,
  input  logic       wr_rest,
  output logic [3:0] note,
  output logic       tone_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  // 32 bits covers 16 * (2^24-1) beats-worth of cycles with room to spare.
  localparam logic [31:0] BEAT = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAPC = 32'(GAP_CYCLES);

  state_t      state, state_next;
  logic [8:0]  tbl [16];
  logic [8:0]  entry;
  logic [31:0] cnt, cnt_next;
  logic [3:0]  note_next, step_next;
  logic        rest_q, rest_next;
  logic        end_step;

  assign entry = tbl[step];

  // Step table: synchronous write in any state, cleared by reset.
  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= {wr_rest, wr_dur, wr_note};
    end
  end

  // Next-state, counter and latch logic; stop overrides everything.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    note_next  = note;
    step_next  = step;
    rest_next  = rest_q;
    end_step   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          step_next  = 4'd0;
        end
      end
      LOAD: begin
        // Latching here is what shields the playing step from table writes.
        note_next  = entry[3:0];
        rest_next  = entry[8];
        cnt_next   = ({28'd0, entry[7:4]} + 32'd1) * BEAT - 32'd1;
        state_next = PLAY;
      end
      PLAY: begin
        if (cnt == 32'd0) begin
          if (GAPC != 32'd0) begin
            state_next = GAP;
            cnt_next   = GAPC - 32'd1;
          end else begin
            end_step = 1'b1;
          end
        end else begin
          cnt_next = cnt - 32'd1;
        end
      end
      GAP: begin
        if (cnt == 32'd0) end_step = 1'b1;
        else              cnt_next = cnt - 32'd1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // loop_en and last_step only matter at this decision point.
    if (end_step) begin
      cnt_next = 32'd0;
      if (step != last_step) begin
        step_next  = step + 4'd1;
        state_next = LOAD;
      end else if (loop_en) begin
        step_next  = 4'd0;
        state_next = LOAD;
      end else begin
        state_next = DONE;
      end
    end

    // Abort: back to IDLE, note and step keep their last values.
    if (stop) begin
      state_next = IDLE;
      cnt_next   = 32'd0;
      note_next  = note;
      step_next  = step;
      rest_next  = rest_q;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      note    <= '0;
      step    <= '0;
      rest_q  <= 1'b0;
      tone_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      note    <= note_next;
      step    <= step_next;
      rest_q  <= rest_next;
      tone_en <= (state_next == PLAY) && !rest_next;
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_buzzer_seq.sv
// Directed testbench for buzzer_seq with BEAT_CYCLES=4, GAP_CYCLES=2.
// Cycle 0 is the cycle in which start is held high; outputs are sampled on
// the falling edge of each cycle.
module tb_buzzer_seq;

  logic       FPGA_CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [3:0] last_step = 4'd0;
  logic       wr_en = 1'b0, wr_rest = 1'b0;
  logic [3:0] wr_addr = 4'd0, wr_note = 4'd0, wr_dur = 4'd0;
  logic [3:0] note, step;
  logic       tone_en, busy, done;

  int checks = 0;
  int errors = 0;

  buzzer_seq #(.BEAT_CYCLES(4), .GAP_CYCLES(2)) dut (
    .FPGA_CLK(FPGA_CLK), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .last_step(last_step), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur), .wr_rest(wr_rest),
    .note(note), .tone_en(tone_en), .busy(busy), .done(done), .step(step)
  );

  // Clock and reset
  always #5 FPGA_CLK = ~FPGA_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge FPGA_CLK);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic rest,
                             input logic [3:0] dur, input logic [3:0] nt);
    wr_en = 1'b1; wr_addr = addr; wr_rest = rest; wr_dur = dur; wr_note = nt;
    tick();
    wr_en = 1'b0;
  endtask

  // Single-step playback from step 0: tone in [tone_lo,tone_hi], done at done_cyc.
  // Optionally pulses start at cycle 4 and rewrites entry 0 (note 9) at cycle 5.
  task automatic play_check(input string tag, input logic [3:0] exp_note,
                            input int tone_lo, input int tone_hi, input int done_cyc,
                            input bit extra_start, input bit wr_mid);
    start = 1'b1;
    for (int c = 0; c <= done_cyc + 1; c++) begin
      @(negedge FPGA_CLK);
      check($sformatf("%s tone c%0d", tag, c), tone_en, (c >= tone_lo && c <= tone_hi));
      check($sformatf("%s busy c%0d", tag, c), busy, (c >= 1 && c <= done_cyc));
      check($sformatf("%s done c%0d", tag, c), done, (c == done_cyc));
      if (c >= 2) check($sformatf("%s note c%0d", tag, c), note, exp_note);
      if (c >= 1) check($sformatf("%s step c%0d", tag, c), step, 0);
      tick();
      start = extra_start && (c + 1 == 4);
      if (wr_mid && (c + 1 == 5)) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_rest = 1'b0; wr_dur = 4'd1; wr_note = 4'd9;
      end else begin
        wr_en = 1'b0;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge FPGA_CLK);
    @(negedge FPGA_CLK);
    check("rst tone", tone_en, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst note", note, 0);
    check("rst step", step, 0);
    rst_n = 1'b1;
    tick();

    // Single step: entry0 = {rest 0, dur 1, note 3}
    write_entry(4'd0, 1'b0, 4'd1, 4'd3);
    play_check("single", 4'd3, 2, 9, 12, 1'b0, 1'b0);

    // Start during PLAY is ignored; write to playing entry does not disturb it
    play_check("busystart", 4'd3, 2, 9, 12, 1'b1, 1'b1);
    play_check("newnote", 4'd9, 2, 9, 12, 1'b0, 1'b0);
    write_entry(4'd0, 1'b0, 4'd1, 4'd3);

    // Rest step: entry1 = {rest 1, dur 0, note 7}
    write_entry(4'd1, 1'b1, 4'd0, 4'd7);
    last_step = 4'd1;
    start = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge FPGA_CLK);
      check($sformatf("rest tone c%0d", c), tone_en, (c >= 2 && c <= 9));
      check($sformatf("rest busy c%0d", c), busy, (c >= 1 && c <= 19));
      check($sformatf("rest done c%0d", c), done, (c == 19));
      if (c >= 12 && c <= 19) check($sformatf("rest step c%0d", c), step, 1);
      if (c >= 13 && c <= 16) check($sformatf("rest note c%0d", c), note, 7);
      tick();
      start = 1'b0;
    end

    // Loop: back to step 0 after step 1's gap, no done
    loop_en = 1'b1;
    start = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      @(negedge FPGA_CLK);
      check($sformatf("loop done c%0d", c), done, 0);
      if (c >= 1) check($sformatf("loop busy c%0d", c), busy, 1);
      if (c == 16) check("loop step1", step, 1);
      if (c == 19) check("loop step0", step, 0);
      if (c == 20) begin
        check("loop tone", tone_en, 1);
        check("loop note", note, 3);
      end
      tick();
      start = 1'b0;
    end
    loop_en = 1'b0;
    stop = 1'b1;               // cycle 22, PLAY of step 0
    tick();
    stop = 1'b0;
    @(negedge FPGA_CLK);
    check("loopstop busy", busy, 0);
    check("loopstop tone", tone_en, 0);
    check("loopstop done", done, 0);
    check("loopstop note", note, 3);
    check("loopstop step", step, 0);
    tick();

    // Stop at cycle 5 of a single step, then replay
    last_step = 4'd0;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      start = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      @(negedge FPGA_CLK);
      check($sformatf("stop tone c%0d", c), tone_en, 0);
      check($sformatf("stop busy c%0d", c), busy, 0);
      check($sformatf("stop done c%0d", c), done, 0);
      check($sformatf("stop note c%0d", c), note, 3);
      tick();
    end
    play_check("replay", 4'd3, 2, 9, 12, 1'b0, 1'b0);

    // Start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge FPGA_CLK);
      check($sformatf("contend busy c%0d", c), busy, 0);
      check($sformatf("contend tone c%0d", c), tone_en, 0);
      tick();
    end

    // Async reset mid-PLAY of step 1, then table must read back as zeros
    write_entry(4'd1, 1'b0, 4'd0, 4'd7);
    last_step = 4'd1;
    start = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      start = 1'b0;
    end
    @(negedge FPGA_CLK);
    check("prerst step", step, 1);
    check("prerst tone", tone_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async tone", tone_en, 0);
    check("async busy", busy, 0);
    check("async step", step, 0);
    check("async note", note, 0);
    @(posedge FPGA_CLK);
    #3 rst_n = 1'b1;
    tick();
    last_step = 4'd0;
    play_check("postrst", 4'd0, 2, 5, 8, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_seq.md
BUZZER_SEQ -- requirements
Module: buzzer_seq

Interface
REQ-001 Parameters (name, default, meaning):
- BEAT_CYCLES, 12500000, clock cycles per beat (250 ms at 50 MHz); legal range 1..2^24-1.
- GAP_CYCLES, 1250000, silent articulation gap after each step; 0 means no gap.
REQ-002 Ports (name, direction, width, meaning):
- FPGA_CLK, in, 1, sole clock; all logic on its rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- start, in, 1, start playback (sampled each cycle).
- stop, in, 1, abort playback (sampled each cycle).
- loop_en, in, 1, restart at step 0 after the last step.
- last_step, in, 4, index of the final step (sequence length = last_step+1).
- wr_en, in, 1, write one step-table entry.
- wr_addr, in, 4, step-table address.
- wr_note, in, 4, note index for the tone generator.
- wr_dur, in, 4, duration code; step lasts wr_dur+1 beats.
- wr_rest, in, 1, 1 = silent step.
- note, out, 4, note index driving the tone generator data input.
- tone_en, out, 1, level gate; 1 = tone audible.
- busy, out, 1, sequencer active.
- done, out, 1, one-cycle pulse on normal completion.
- step, out, 4, index of the step currently loaded.

Function
REQ-003 The step table SHALL hold 16 entries x 9 bits {rest, dur[3:0], note[3:0]}, written synchronously when wr_en=1, in any state.
REQ-004 The FSM SHALL have exactly these states: IDLE, LOAD, PLAY, GAP, DONE.
REQ-005 IDLE: start=1 and stop=0 -> LOAD with step=0; otherwise remain in IDLE.
REQ-006 LOAD, one cycle: latch the table entry at step into note, the rest flag and the duration counter; next state PLAY.
REQ-007 PLAY SHALL last exactly (dur+1)*BEAT_CYCLES cycles, then -> GAP, or -> the end-of-step decision when GAP_CYCLES=0.
REQ-008 GAP SHALL last exactly GAP_CYCLES cycles, then -> the end-of-step decision.
REQ-009 End-of-step decision:
- step<last_step: step+1, -> LOAD.
- step=last_step and loop_en=1: step=0, -> LOAD.
- otherwise: -> DONE.
REQ-010 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-011 tone_en SHALL be registered and equal 1 only in PLAY cycles whose latched rest flag is 0; it is 0 in IDLE, LOAD, GAP and DONE.
REQ-012 Timing: tone_en rises 2 cycles after start is sampled. Between consecutive non-rest steps, tone_en is low for exactly GAP_CYCLES+1 cycles.
REQ-013 busy SHALL be 1 in LOAD, PLAY, GAP and DONE, and 0 in IDLE.
REQ-014 stop=1 in any state SHALL force IDLE on the next edge with tone_en=0 and busy=0; done is not pulsed; note and step hold their values.
REQ-015 start and stop sampled together SHALL let stop win.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 A table write to the entry currently playing SHALL NOT alter the current step; it takes effect the next time that entry is loaded.
REQ-018 loop_en and last_step SHALL be sampled only at the end-of-step decision.
REQ-019 Counters SHALL be wide enough for 16*BEAT_CYCLES without wrap-around. step wraps 15->0 only via the loop rule.

Reset
REQ-020 When rst_n=0, the block SHALL asynchronously force: state=IDLE, note=0, tone_en=0, busy=0, done=0, step=0, and all counters to 0.
REQ-021 Reset SHALL clear the step table to all zeros.
REQ-022 Release of rst_n SHALL be honoured on the next FPGA_CLK edge. Reset mid-playback SHALL behave identically to reset from idle.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2)
REQ-023 Single step:
- Stimulus: entry0={0,1,3}, last_step=0, loop_en=0, start pulse at cycle 0.
- Response: note=3 from cycle 2; tone_en=1 in cycles 2-9; done=1 at cycle 12; busy=0 at cycle 13.
REQ-024 Rest step:
- Stimulus: entry1={1,0,7}, entry0 as in REQ-023, last_step=1.
- Response: tone_en stays 0 for the 4 PLAY cycles of step 1 while note=7.
REQ-025 Loop:
- Stimulus: last_step=1, loop_en=1.
- Response: after step 1's GAP, step returns to 0, LOAD occurs, done never pulses, busy stays 1.
REQ-026 Stop:
- Stimulus: stop at cycle 5 of REQ-023.
- Response: tone_en=0 and busy=0 from cycle 6; no done pulse; a subsequent start replays from step 0.
REQ-027 Start/stop contention:
- Stimulus: start and stop in the same IDLE cycle.
- Response: state stays IDLE.
- Stimulus: start pulse during PLAY.
- Response: timing unchanged.
REQ-028 Async reset:
- Stimulus: rst_n low mid-PLAY, between clock edges.
- Response: tone_en, busy and step drop to 0 immediately; the table reads all zeros after release.
